// File: rtl/sp_ram_arbiter_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Requester IDs double as the round-robin pointer encoding.
package sp_ram_arbiter_pkg;

  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 64;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_t;

endpackage

// File: rtl/single_port_ram.sv
// Single-port synchronous RAM, one-cycle registered read.
// Read returns the word held before a same-edge write.
module single_port_ram #(
  parameter int data_width = 8,
  parameter int addr_width = 6,
  parameter int depth      = 64
) (
  input  logic [data_width-1:0] data,
  input  logic [addr_width-1:0] addr,
  input  logic                  we,
  input  logic                  clk,
  output logic [data_width-1:0] q
);

  logic [data_width-1:0] ram [depth];

  always_ff @(posedge clk) begin
    if (we)
      ram[addr] <= data;
    q <= ram[addr];
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single_port_ram between
// requesters A and B, with a two-stage read response pipeline.
import sp_ram_arbiter_pkg::*;

module sp_ram_arbiter #(
  parameter int addr_width = ADDR_WIDTH,
  parameter int data_width = DATA_WIDTH,
  parameter int depth      = DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [addr_width-1:0] a_addr,
  input  logic [data_width-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [data_width-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [addr_width-1:0] b_addr,
  input  logic [data_width-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [data_width-1:0] b_rdata
);

  req_t                  ptr;
  logic                  gnt_a;
  logic                  gnt_b;
  logic                  ram_we;
  logic [addr_width-1:0] ram_addr;
  logic [data_width-1:0] ram_data;
  logic [data_width-1:0] ram_q;
  logic                  s1_vld;
  req_t                  s1_own;

  // A wins unless B is also asking and A went last
  assign gnt_a   = a_valid && (!b_valid || ptr == REQ_B);
  assign gnt_b   = b_valid && !gnt_a;
  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_we   = 1'b0;
    unique case (1'b1)
      gnt_a: begin
        ram_addr = a_addr;
        ram_data = a_wdata;
        ram_we   = a_we && !rst;
      end
      gnt_b: begin
        ram_addr = b_addr;
        ram_data = b_wdata;
        ram_we   = b_we && !rst;
      end
      default: ;
    endcase
  end

  single_port_ram #(
    .data_width(data_width),
    .addr_width(addr_width),
    .depth     (depth)
  ) u_ram (
    .data(ram_data),
    .addr(ram_addr),
    .we  (ram_we),
    .clk (clk),
    .q   (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= REQ_B;
      s1_vld   <= 1'b0;
      s1_own   <= REQ_A;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      if (gnt_a || gnt_b)
        ptr <= gnt_a ? REQ_A : REQ_B;
      s1_vld   <= (gnt_a && !a_we) || (gnt_b && !b_we);
      s1_own   <= gnt_b ? REQ_B : REQ_A;
      a_rvalid <= s1_vld && s1_own == REQ_A;
      b_rvalid <= s1_vld && s1_own == REQ_B;
      if (s1_vld && s1_own == REQ_A)
        a_rdata <= ram_q;
      if (s1_vld && s1_own == REQ_B)
        b_rdata <= ram_q;
    end
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter: vector table plus
// hand sequences for reset behaviour.
module tb_sp_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, a_ready, a_we, a_rvalid;
  logic [5:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic       b_valid, b_ready, b_we, b_rvalid;
  logic [5:0] b_addr;
  logic [7:0] b_wdata, b_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sp_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we),
    .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  typedef struct {
    logic       av, awe;
    logic [5:0] aad;
    logic [7:0] awd;
    logic       bv, bwe;
    logic [5:0] bad;
    logic [7:0] bwd;
    logic       ear, ebr, earv;
    logic [7:0] eard;
    logic       ebrv;
    logic [7:0] ebrd;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic av, awe, input logic [5:0] aad,
                     input logic [7:0] awd,
                     input logic bv, bwe, input logic [5:0] bad,
                     input logic [7:0] bwd,
                     input logic ear, ebr, earv, input logic [7:0] eard,
                     input logic ebrv, input logic [7:0] ebrd);
    vec_t v;
    v.av = av; v.awe = awe; v.aad = aad; v.awd = awd;
    v.bv = bv; v.bwe = bwe; v.bad = bad; v.bwd = bwd;
    v.ear = ear; v.ebr = ebr; v.earv = earv; v.eard = eard;
    v.ebrv = ebrv; v.ebrd = ebrd;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input int step,
                     input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h want %h", nm, step, act, exp);
    end
  endtask

  task automatic drive(input logic av, awe, input logic [5:0] aad,
                       input logic [7:0] awd,
                       input logic bv, bwe, input logic [5:0] bad,
                       input logic [7:0] bwd);
    @(negedge clk);
    a_valid = av; a_we = awe; a_addr = aad; a_wdata = awd;
    b_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd;
    #1;
  endtask

  task automatic chk_out(input string nm, input int step,
                         input logic ar, br, arv, input logic [7:0] ard,
                         input logic brv, input logic [7:0] brd);
    chk({nm, ".a_ready"}, step, {7'b0, a_ready}, {7'b0, ar});
    chk({nm, ".b_ready"}, step, {7'b0, b_ready}, {7'b0, br});
    chk({nm, ".a_rvalid"}, step, {7'b0, a_rvalid}, {7'b0, arv});
    chk({nm, ".a_rdata"}, step, a_rdata, ard);
    chk({nm, ".b_rvalid"}, step, {7'b0, b_rvalid}, {7'b0, brv});
    chk({nm, ".b_rdata"}, step, b_rdata, brd);
  endtask

  initial begin
    // single requester: writes then back-to-back reads
    add(1,1,0,8'h01, 0,0,0,0, 1,0, 0,8'h00, 0,8'h00);
    add(1,1,1,8'h02, 0,0,0,0, 1,0, 0,8'h00, 0,8'h00);
    add(1,1,2,8'h03, 0,0,0,0, 1,0, 0,8'h00, 0,8'h00);
    add(1,0,0,8'h00, 0,0,0,0, 1,0, 0,8'h00, 0,8'h00);
    add(1,0,1,8'h00, 0,0,0,0, 1,0, 0,8'h00, 0,8'h00);
    add(1,0,2,8'h00, 0,0,0,0, 1,0, 1,8'h01, 0,8'h00);
    add(0,0,0,8'h00, 0,0,0,0, 0,0, 1,8'h02, 0,8'h00);
    add(0,0,0,8'h00, 1,1,1,8'h02, 0,1, 1,8'h03, 0,8'h00);
    // contention: A reads @0, B reads @1
    add(1,0,0,8'h00, 1,0,1,8'h00, 1,0, 0,8'h03, 0,8'h00);
    add(1,0,0,8'h00, 1,0,1,8'h00, 0,1, 0,8'h03, 0,8'h00);
    add(1,0,0,8'h00, 1,0,1,8'h00, 1,0, 1,8'h01, 0,8'h00);
    add(1,0,0,8'h00, 1,0,1,8'h00, 0,1, 0,8'h01, 1,8'h02);
    add(1,0,0,8'h00, 1,0,1,8'h00, 1,0, 1,8'h01, 0,8'h02);
    add(1,0,0,8'h00, 1,0,1,8'h00, 0,1, 0,8'h01, 1,8'h02);
    add(1,0,0,8'h00, 1,0,1,8'h00, 1,0, 1,8'h01, 0,8'h02);
    add(0,0,0,8'h00, 1,0,1,8'h00, 0,1, 0,8'h01, 1,8'h02);
    // hazard at address 5
    add(1,1,5,8'h11, 0,0,0,0, 1,0, 1,8'h01, 0,8'h02);
    add(1,0,5,8'h00, 0,0,0,0, 1,0, 0,8'h01, 1,8'h02);
    add(0,0,0,8'h00, 1,1,5,8'h22, 0,1, 0,8'h01, 0,8'h02);
    add(1,0,5,8'h00, 0,0,0,0, 1,0, 1,8'h11, 0,8'h02);
    add(0,0,0,8'h00, 0,0,0,0, 0,0, 0,8'h11, 0,8'h02);
    add(0,0,0,8'h00, 0,0,0,0, 0,0, 1,8'h22, 0,8'h02);
    // pointer hold: three B transfers, then contention
    add(0,0,0,8'h00, 1,1,6,8'h33, 0,1, 0,8'h22, 0,8'h02);
    add(0,0,0,8'h00, 1,1,7,8'h34, 0,1, 0,8'h22, 0,8'h02);
    add(0,0,0,8'h00, 1,0,6,8'h00, 0,1, 0,8'h22, 0,8'h02);
    add(1,0,7,8'h00, 1,0,5,8'h00, 1,0, 0,8'h22, 0,8'h02);
    add(0,0,0,8'h00, 1,0,5,8'h00, 0,1, 0,8'h22, 1,8'h33);
    add(0,0,0,8'h00, 0,0,0,0, 0,0, 1,8'h34, 0,8'h33);
    add(0,0,0,8'h00, 0,0,0,0, 0,0, 0,8'h34, 1,8'h22);
    add(0,0,0,8'h00, 0,0,0,0, 0,0, 0,8'h34, 0,8'h22);

    rst = 1'b1;
    a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    #1;
    chk_out("reset", 0, 0, 0, 0, 8'h00, 0, 8'h00);
    drive(1,0,0,8'h00, 1,0,0,8'h00);
    chk_out("reset_both", 0, 1, 0, 0, 8'h00, 0, 8'h00);
    drive(0,0,0,8'h00, 0,0,0,8'h00);
    rst = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i].av, tv[i].awe, tv[i].aad, tv[i].awd,
            tv[i].bv, tv[i].bwe, tv[i].bad, tv[i].bwd);
      chk_out("vec", i, tv[i].ear, tv[i].ebr, tv[i].earv,
              tv[i].eard, tv[i].ebrv, tv[i].ebrd);
    end

    // reset between the accept edge and the next edge
    drive(1,0,0,8'h00, 0,0,0,8'h00);
    @(posedge clk);
    #2;
    rst = 1'b1;
    a_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b0;
      #1;
      chk("midrst.a_rvalid", k, {7'b0, a_rvalid}, 8'h00);
      chk("midrst.a_rdata", k, a_rdata, 8'h00);
    end
    drive(1,0,0,8'h00, 0,0,0,8'h00);
    drive(0,0,0,8'h00, 0,0,0,8'h00);
    chk_out("midrst_re1", 1, 0, 0, 0, 8'h00, 0, 8'h00);
    drive(0,0,0,8'h00, 0,0,0,8'h00);
    chk_out("midrst_re2", 2, 0, 0, 1, 8'h01, 0, 8'h00);

    // writes presented during reset must not land
    drive(1,1,0,8'hEE, 1,1,1,8'hEE);
    rst = 1'b1;
    #1;
    chk_out("rstwr", 0, 1, 0, 0, 8'h00, 0, 8'h00);
    drive(1,1,0,8'hEE, 1,1,1,8'hEE);
    chk_out("rstwr", 1, 1, 0, 0, 8'h00, 0, 8'h00);
    drive(1,0,0,8'h00, 1,0,1,8'h00);
    rst = 1'b0;
    #1;
    chk_out("post_rst", 0, 1, 0, 0, 8'h00, 0, 8'h00);
    drive(0,0,0,8'h00, 1,0,1,8'h00);
    chk_out("post_rst", 1, 0, 1, 0, 8'h00, 0, 8'h00);
    drive(0,0,0,8'h00, 0,0,0,8'h00);
    chk_out("post_rst", 2, 0, 0, 1, 8'h01, 0, 8'h00);
    drive(0,0,0,8'h00, 0,0,0,8'h00);
    chk_out("post_rst", 3, 0, 0, 0, 8'h01, 1, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  always @(negedge clk)
    if (a_rvalid && b_rvalid) begin
      n_chk++;
      n_err++;
      $display("FAIL both_rvalid: got 1 want 0");
    end

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Two-requester round-robin arbiter in front of the 64x8 `single_port_ram`. It owns one instance of the RAM and shares its single port between requesters A and B. Each requester uses a valid/ready request channel and a one-cycle read-response strobe. One access is issued per clock, with full throughput when a single requester is active.

## Interface
- `addr_width`, default 6, RAM address width.
- `data_width`, default 8, RAM word width.
- `depth`, default 64, RAM words; must equal 2**addr_width.
- `clk` input 1 — single clock; all state on rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `a_valid` input 1 — A request present.
- `a_ready` output 1 — A request accepted this cycle (combinational grant).
- `a_we` input 1 — 1 = write, 0 = read.
- `a_addr` input addr_width — A address.
- `a_wdata` input data_width — A write data.
- `a_rvalid` output 1 — one-cycle strobe: `a_rdata` holds A's read result.
- `a_rdata` output data_width — A read data.
- `b_valid`, `b_ready`, `b_we`, `b_addr`, `b_wdata`, `b_rvalid`, `b_rdata` — identical set for requester B.

## Operation
- **Handshake:** a request transfers at a rising edge where valid && ready.
  - The requester holds `we`, `addr` and `wdata` stable from valid-high until the transfer.
  - Ready may depend combinationally on valid. Valid must not depend on ready.
- **Grant:**
  - Exactly one of `a_ready`/`b_ready` is high in any cycle with at least one valid. Both are low when neither is valid.
  - Only one valid: that requester is granted, whatever the pointer holds.
  - Both valid: the requester not granted last is granted.
- **Pointer:** one-bit state LAST_A / LAST_B.
  - Updates only on a transfer, to the granted requester.
  - Reset value is LAST_B, so A wins the first contention.
- **RAM drive (combinational from grant):**
  - RAM `addr`/`data` come from the granted requester.
  - RAM `we` = granted valid && granted `we`.
  - Idle cycles drive `addr`=0, `data`=0, `we`=0.
- **Write:** the RAM word is updated at the transfer edge. No response is generated.
- **Read pipeline:**
  - Stage 1 registers {read_issued, owner} at the transfer edge. The RAM `q` is valid in the following cycle.
  - Stage 2 captures `q` into the owner's `rdata` register and pulses that owner's `rvalid` for one cycle.
  - Reads return in issue order. Both `rvalid` outputs are never high together.
- **Ordering hazards:**
  - A read returns memory content from before any write accepted at a later edge, including a write to the same address on the next cycle.
  - A write accepted before a read, even one cycle earlier and from the other requester, is visible to that read.
- **`rdata` hold:** an `rdata` register holds its last value until the next read for that requester completes.

## Timing
- Reset values: `a_rvalid`=0, `b_rvalid`=0, `a_rdata`=0, `b_rdata`=0, pointer=LAST_B, both pipeline stages empty. `a_ready`/`b_ready` follow the valids combinationally, including during reset.
- Read accepted at edge N: `rvalid`/`rdata` are valid during the cycle after edge N+1 (response latency 2). `rvalid` is high for exactly one cycle.
- Throughput: one transfer per cycle. With continuous contention, grants alternate A, B, A, B.
- Reset asserted mid-operation clears both pipeline stages immediately. In-flight reads produce no `rvalid`, before or after reset release. RAM contents are not cleared.
- Transfers occurring while `rst` is high are ignored: no write, no response.

## Structure
- Shared package holds:
  - ADDR_WIDTH=6, DATA_WIDTH=8, DEPTH=64 defaults;
  - requester-ID encoding (REQ_A=0, REQ_B=1), also used as the pointer encoding.
- One sub-module: the existing `single_port_ram`, instantiated unmodified with ports `data`, `addr`, `we`, `clk`, `q`.
- Arbiter logic, pointer and the two-stage response pipeline live in `sp_ram_arbiter` itself.

## Test plan
- **Reset:** hold `rst` with both valids high. Expect all rvalid/rdata = 0 and no RAM write. After release, the first contention grants A.
- **Single requester:**
  - A writes 0x01@0, 0x02@1, 0x03@2 on consecutive cycles, then reads addresses 0, 1, 2 back-to-back.
  - Expect `a_rvalid` on 3 consecutive cycles starting 2 cycles after the first read, with `a_rdata` = 0x01, 0x02, 0x03.
  - `b_rvalid` stays 0 throughout.
- **Contention:**
  - Setup: A reads @0, B reads @1, both valid continuously for 4 transfers each.
  - Expect grants A, B, A, B, ….
  - Expect `a_rdata`=0x01 and `b_rdata`=0x02 on alternating strobes, never simultaneous.
- **Hazard:**
  - Setup: A reads @5 (holding 0x11), then B writes 0x22@5 on the next edge, then A reads @5.
  - Expect A's first response = 0x11 and its second response = 0x22.
- **Reset mid-read:**
  - A read is accepted at edge N; assert `rst` between N and N+1.
  - Expect no `a_rvalid` at any time and `a_rdata` = 0.
  - After release, a new read of the same address returns the stored value.
- **Pointer hold:** B alone transfers 3 times, then A and B become valid together. Expect A granted first, because the pointer is LAST_B.
